// File: rtl/alu_issue_ctrl.sv
// Multi-cycle, non-pipelined ALU issue front end: accepts one RV32 instruction,
// decodes it, drives the combinational ALU and issues a single-cycle writeback.
module alu_issue_ctrl #(
  parameter int ALU_OP_W = 5,
  parameter int ZERO_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [31:0]         inst,
  input  logic [31:0]         inst_pc,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  input  logic [31:0]         rs1_data,
  input  logic [31:0]         rs2_data,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_c,
  input  logic [ZERO_W-1:0]   alu_zero,
  output logic                wb_en,
  output logic [4:0]          wb_addr,
  output logic [31:0]         wb_data,
  output logic                zero_flag,
  output logic                illegal,
  output logic [31:0]         retire_cnt
);

  localparam logic [ALU_OP_W-1:0] OP_NOP   = ALU_OP_W'(3'd0);
  localparam logic [ALU_OP_W-1:0] OP_LUI   = ALU_OP_W'(3'd1);
  localparam logic [ALU_OP_W-1:0] OP_AUIPC = ALU_OP_W'(3'd2);
  localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(3'd3);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [31:0]           inst_r;
  logic [31:0]           pc_r;
  logic [31:0]           alu_a_r;
  logic [31:0]           alu_b_r;
  logic [ALU_OP_W-1:0]   alu_op_r;
  logic                  wb_en_r;
  logic [4:0]            wb_addr_r;
  logic [31:0]           wb_data_r;
  logic                  zero_flag_r;
  logic                  illegal_r;
  logic [31:0]           retire_cnt_r;

  logic                  dec_legal_s;
  logic [ALU_OP_W-1:0]   dec_op_s;
  logic [31:0]           dec_a_s;
  logic [31:0]           dec_b_s;
  logic                  inst_ready_s;
  logic                  accept_s;
  logic                  ld_ops_s;
  logic                  clr_ops_s;
  logic                  capture_s;
  logic                  illegal_s;
  logic                  unused_zero_s;

  // Only bit 0 of the ALU zero flag carries information.
  assign unused_zero_s = ^alu_zero[ZERO_W-1:1];

  assign rs1_addr = inst_r[19:15];
  assign rs2_addr = inst_r[24:20];

  // Instruction decode from the latched word and the live register-file read data
  always_comb begin
    dec_legal_s = 1'b0;
    dec_op_s    = OP_NOP;
    dec_a_s     = 32'd0;
    dec_b_s     = 32'd0;
    case (inst_r[6:0])
      OPC_LUI: begin
        dec_legal_s = 1'b1;
        dec_op_s    = OP_LUI;
        dec_b_s     = {inst_r[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec_legal_s = 1'b1;
        dec_op_s    = OP_AUIPC;
        dec_a_s     = pc_r;
        dec_b_s     = {inst_r[31:12], 12'd0};
      end
      OPC_OP: begin
        if ((inst_r[14:12] == 3'd0) && (inst_r[31:25] == 7'd0)) begin
          dec_legal_s = 1'b1;
          dec_op_s    = OP_ADD;
          dec_a_s     = rs1_data;
          dec_b_s     = rs2_data;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (inst_r[14:12] == 3'd0) begin
          dec_legal_s = 1'b1;
          dec_op_s    = OP_ADD;
          dec_a_s     = rs1_data;
          dec_b_s     = sext12(inst_r[31:20]);
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an illegal instruction skips EXEC/WB
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (inst_valid) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DECODE: begin
        if (dec_legal_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC:  state_nxt_s = S_WB;
      S_WB:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-state control strobes; ready is masked directly by reset
  always_comb begin
    inst_ready_s = rstn & (state_r == S_IDLE);
    accept_s     = inst_valid & inst_ready_s;
    ld_ops_s     = (state_r == S_DECODE) & dec_legal_s;
    illegal_s    = (state_r == S_DECODE) & ~dec_legal_s;
    capture_s    = (state_r == S_EXEC);
    clr_ops_s    = (state_r == S_WB);
  end

  // Instruction and PC latch at the handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_r <= 32'd0;
      pc_r   <= 32'd0;
    end else if (accept_s) begin
      inst_r <= inst;
      pc_r   <= inst_pc;
    end else begin
      inst_r <= inst_r;
      pc_r   <= pc_r;
    end
  end

  // ALU operand registers: loaded after DECODE, held through EXEC/WB, cleared leaving WB
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      alu_op_r  <= OP_NOP;
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_s;
      if (ld_ops_s) begin
        alu_a_r  <= dec_a_s;
        alu_b_r  <= dec_b_s;
        alu_op_r <= dec_op_s;
      end else if (clr_ops_s) begin
        alu_a_r  <= 32'd0;
        alu_b_r  <= 32'd0;
        alu_op_r <= OP_NOP;
      end else begin
        alu_a_r  <= alu_a_r;
        alu_b_r  <= alu_b_r;
        alu_op_r <= alu_op_r;
      end
    end
  end

  // Result capture at the end of EXEC; the WB cycle sees strobe, data and count together
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_en_r      <= 1'b0;
      wb_addr_r    <= 5'd0;
      wb_data_r    <= 32'd0;
      zero_flag_r  <= 1'b0;
      retire_cnt_r <= 32'd0;
    end else if (capture_s) begin
      wb_en_r      <= (inst_r[11:7] != 5'd0);
      wb_addr_r    <= inst_r[11:7];
      wb_data_r    <= alu_c;
      zero_flag_r  <= alu_zero[0];
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      wb_en_r      <= 1'b0;
      wb_addr_r    <= wb_addr_r;
      wb_data_r    <= wb_data_r;
      zero_flag_r  <= zero_flag_r;
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign inst_ready = inst_ready_s;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign wb_en      = wb_en_r;
  assign wb_addr    = wb_addr_r;
  assign wb_data    = wb_data_r;
  assign zero_flag  = zero_flag_r;
  assign illegal    = illegal_r;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Producer side of the ALU operand interface.
- Accepts one instruction at a time over a valid/ready handshake and decodes it.
- Reads the register file through combinational read ports, then drives A/B/ALUOp into the combinational ALU.
- Captures the ALU result C and Zero, and issues a one-cycle register-file writeback.
- Multi-cycle, non-pipelined front end for the lab datapath.

Parameters:
- ALU_OP_W, 5, ALUOp width; fixed encodings: nop=0, lui=1, auipc=2, add=3.
- ZERO_W, 8, width of the ALU Zero flag input; only bit 0 is meaningful.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  block can accept an instruction.
- inst  in  32  RV32 instruction word.
- inst_pc  in  32  PC of the offered instruction.
- rs1_addr  out  5  register-file read address, port 1.
- rs2_addr  out  5  register-file read address, port 2.
- rs1_data  in  32  combinational read data, port 1.
- rs2_data  in  32  combinational read data, port 2.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  ALU_OP_W  ALU operation.
- alu_c  in  32  ALU result.
- alu_zero  in  ZERO_W  ALU zero flag.
- wb_en  out  1  writeback strobe, one cycle.
- wb_addr  out  5  writeback destination register.
- wb_data  out  32  writeback value.
- zero_flag  out  1  alu_zero[0] captured at writeback.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- retire_cnt  out  32  count of completed legal instructions.

Behaviour:
- Reset (async, rstn low):
  - state=IDLE.
  - inst_ready forced 0 while rstn is low.
  - All registered outputs cleared: alu_a/alu_b=0, alu_op=nop, wb_en=0, wb_addr=0, wb_data=0, zero_flag=0, illegal=0, retire_cnt=0.
  - Reset mid-instruction discards that instruction with no writeback.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - inst_ready=1.
  - Transfer occurs on a rising edge with inst_valid&inst_ready. inst and inst_pc are latched and the state goes to DECODE.
  - inst_ready=0 in every other state; inst_valid is ignored there.
- DECODE:
  - rs1_addr=inst[19:15] and rs2_addr=inst[24:20], driven from the latched instruction.
  - At the end of the cycle, alu_a/alu_b/alu_op are registered per the decode rules below, and the state goes to EXEC.
- Decode rules:
  - LUI (opcode 0110111): op=lui, A=0, B={inst[31:12],12'b0}.
  - AUIPC (opcode 0010111): op=auipc, A=inst_pc, B={inst[31:12],12'b0}.
  - ADD (opcode 0110011, funct3=000, funct7=0000000): op=add, A=rs1_data, B=rs2_data.
  - ADDI (opcode 0010011, funct3=000): op=add, A=rs1_data, B=sign-extended inst[31:20].
  - Anything else is illegal: illegal=1 for exactly the cycle after DECODE, alu_op stays nop, no writeback, retire_cnt unchanged, and the state returns to IDLE.
- EXEC:
  - alu_a/alu_b/alu_op are held stable for the full cycle.
  - At the end of the cycle, alu_c goes into wb_data and alu_zero[0] into zero_flag. State goes to WB.
- WB:
  - wb_en=1 for exactly this cycle, with wb_addr=inst[11:7].
  - If rd=0, wb_en stays 0, but wb_data and zero_flag are still updated.
  - retire_cnt increments by 1, wrapping 0xFFFFFFFF -> 0.
  - Leaving WB: alu_op returns to nop and alu_a/alu_b return to 0. State goes to IDLE.
- Latency:
  - Acceptance edge at cycle 0; wb_en is high in cycle 3.
  - inst_ready is high again in cycle 4.
  - Throughput is one instruction per 4 cycles. An illegal instruction occupies 2 cycles.
- wb_data and zero_flag hold their values until the next legal instruction reaches WB.
- Arithmetic is 32-bit wrap-around; the ALU's result width is not extended.

Test Plan:
- LUI x5,0x12345 (inst=0x123452B7) -> EXEC: alu_op=1, alu_a=0, alu_b=0x12345000. Cycle 3: wb_en=1, wb_addr=5, wb_data=0x12345000, retire_cnt=1.
- AUIPC x1,0x1 (inst=0x00001097, inst_pc=0x00000100) -> alu_op=2, alu_a=0x100, alu_b=0x1000. Writeback: wb_data=0x00001100, wb_addr=1.
- ADD x3,x1,x2 (inst=0x002081B3, rs1_data=7, rs2_data=0xFFFFFFF9) -> rs1_addr=1, rs2_addr=2, alu_op=3. Writeback: wb_data=0, zero_flag=1. Then ADDI x4,x1,-1 (inst=0xFFF08213, rs1_data=0) -> alu_b=0xFFFFFFFF, wb_data=0xFFFFFFFF, zero_flag=0.
- ADDI x0,x0,5 (inst=0x00500013) -> wb_en stays 0 for the whole instruction, retire_cnt increments, inst_ready returns in cycle 4.
- inst=0x00000000 -> illegal pulses for one cycle, alu_op stays 0, no wb_en, retire_cnt unchanged, inst_ready=1 two cycles after acceptance. inst_valid held high with a second instruction during the busy cycles -> that instruction is not accepted until inst_ready=1.
- rstn driven low during EXEC of an ADD -> all outputs are 0 immediately, with no clock edge needed; no wb_en afterwards. After release, a LUI completes normally with retire_cnt=1.
